// File: rtl/max_pool_stream.sv
// Streaming STRIDE x STRIDE max-pooling over a channel-major raster of Q8.8 samples.
// Emits one window maximum plus a one-hot argmax routing mask per completed window.
module max_pool_stream #(
   parameter int INPUT_WIDTH    = 62,
   parameter int INPUT_HEIGHT   = 62,
   parameter int INPUT_CHANNELS = 30,
   parameter int STRIDE         = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] input_data,
   input  logic        input_valid,
   output logic [15:0] pooled_output,
   output logic        output_valid,
   output logic        pool_done,
   output logic [15:0] output_error,
   output logic        backprop_done
);

   localparam int OUT_W = INPUT_WIDTH / STRIDE;
   localparam int OUT_H = INPUT_HEIGHT / STRIDE;
   localparam int XW    = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
   localparam int YW    = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1;
   localparam int CW    = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1;
   localparam int SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam int OXW   = $clog2(OUT_W + 1);
   localparam int OYW   = $clog2(OUT_H + 1);
   localparam int BUF_D = 1 << OXW;

   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [CW-1:0]  c_q, c_d;
   logic [SW-1:0]  dx_q, dx_d, dy_q, dy_d;
   logic [OXW-1:0] ox_q, ox_d;
   logic [OYW-1:0] oy_q, oy_d;

   logic [15:0] rb_max_q [BUF_D];
   logic [3:0]  rb_idx_q [BUF_D];

   logic [15:0] pooled_q;
   logic [15:0] err_q;
   logic        valid_q;
   logic        done_q;
   logic        bp_q;

   logic        accept;
   logic        x_last, y_last, c_last, dx_last, dy_last;
   logic        in_region;
   logic        first;
   logic        take_new;
   logic [3:0]  cur_k;
   logic [15:0] rd_max;
   logic [3:0]  rd_idx;
   logic [15:0] win_max;
   logic [3:0]  win_idx;
   logic        win_done;
   logic        frame_last;

   assign accept  = enable & input_valid;
   assign x_last  = (x_q == XW'(INPUT_WIDTH - 1));
   assign y_last  = (y_q == YW'(INPUT_HEIGHT - 1));
   assign c_last  = (c_q == CW'(INPUT_CHANNELS - 1));
   assign dx_last = (dx_q == SW'(STRIDE - 1));
   assign dy_last = (dy_q == SW'(STRIDE - 1));

   // ox/oy reach OUT_W/OUT_H only on the trailing columns/rows that floor pooling drops
   assign in_region = (ox_q < OXW'(OUT_W)) && (oy_q < OYW'(OUT_H));

   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      c_d  = c_q;
      dx_d = dx_q;
      dy_d = dy_q;
      ox_d = ox_q;
      oy_d = oy_q;
      if (accept) begin
         if (x_last) begin
            x_d  = '0;
            dx_d = '0;
            ox_d = '0;
            if (y_last) begin
               y_d  = '0;
               dy_d = '0;
               oy_d = '0;
               c_d  = c_last ? '0 : c_q + 1'b1;
            end else begin
               y_d = y_q + 1'b1;
               if (dy_last) begin
                  dy_d = '0;
                  oy_d = oy_q + 1'b1;
               end else begin
                  dy_d = dy_q + 1'b1;
               end
            end
         end else begin
            x_d = x_q + 1'b1;
            if (dx_last) begin
               dx_d = '0;
               ox_d = ox_q + 1'b1;
            end else begin
               dx_d = dx_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      rd_max   = rb_max_q[ox_q];
      rd_idx   = rb_idx_q[ox_q];
      first    = (dx_q == '0) && (dy_q == '0);
      cur_k    = 4'(int'(dy_q) * STRIDE + int'(dx_q));
      // strict compare: on ties the earlier (lower k) position keeps the win
      take_new = first || ($signed(input_data) > $signed(rd_max));
      win_max  = take_new ? input_data : rd_max;
      win_idx  = take_new ? cur_k : rd_idx;
      win_done   = accept && in_region && dx_last && dy_last;
      frame_last = accept && x_last && y_last && c_last;
   end

   always_ff @(posedge clk) begin
      if (accept && in_region) begin
         rb_max_q[ox_q] <= win_max;
         rb_idx_q[ox_q] <= win_idx;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q      <= '0;
         y_q      <= '0;
         c_q      <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
         pooled_q <= '0;
         err_q    <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         bp_q     <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         c_q     <= c_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         valid_q <= win_done;
         done_q  <= frame_last;
         bp_q    <= done_q;
         if (win_done) begin
            pooled_q <= win_max;
            err_q    <= 16'h1 << win_idx;
         end
      end
   end

   assign pooled_output = pooled_q;
   assign output_error  = err_q;
   assign output_valid  = valid_q;
   assign pool_done     = done_q;
   assign backprop_done = bp_q;

endmodule

// File: tb/tb_max_pool_stream.sv
// Bench for max_pool_stream: a 4x4x1 instance driven from a frame table and a 5x5x2
// instance, both checked cycle by cycle against a window-max reference and scoreboard.
module tb_max_pool_stream;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en [2];
   logic        vl [2];
   logic [15:0] din [2];
   logic [15:0] po [2];
   logic [15:0] oe [2];
   logic        ov [2];
   logic        pd [2];
   logic        bd [2];

   int W [2] = '{4, 5};
   int H [2] = '{4, 5};
   int C [2] = '{1, 2};

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int mx [2];
   int my [2];
   int mc [2];
   int exp_win_at  [2];
   int exp_last_at [2];
   logic [15:0] img [2][8][8];

   logic [31:0] sb0 [$];
   logic [31:0] sb1 [$];
   logic [31:0] cap0 [$];
   logic [31:0] cap1 [$];

   typedef struct {
      logic [15:0] px   [16];
      logic [15:0] pool [4];
      logic [15:0] err  [4];
   } frame_t;
   frame_t tbl [4];

   always #5 clk = ~clk;

   max_pool_stream #(.INPUT_WIDTH(4), .INPUT_HEIGHT(4), .INPUT_CHANNELS(1), .STRIDE(S)) u_a (
      .clk(clk), .reset(rst_n), .enable(en[0]), .input_data(din[0]), .input_valid(vl[0]),
      .pooled_output(po[0]), .output_valid(ov[0]), .pool_done(pd[0]),
      .output_error(oe[0]), .backprop_done(bd[0]));

   max_pool_stream #(.INPUT_WIDTH(5), .INPUT_HEIGHT(5), .INPUT_CHANNELS(2), .STRIDE(S)) u_b (
      .clk(clk), .reset(rst_n), .enable(en[1]), .input_data(din[1]), .input_valid(vl[1]),
      .pooled_output(po[1]), .output_valid(ov[1]), .pool_done(pd[1]),
      .output_error(oe[1]), .backprop_done(bd[1]));

   task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, d, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         mx[d] = 0;
         my[d] = 0;
         mc[d] = 0;
         exp_win_at[d]  = -10;
         exp_last_at[d] = -10;
      end
      sb0.delete();
      sb1.delete();
   endtask

   // Drive one cycle of stimulus on dut d and record what it must produce one edge later.
   task automatic drive(input int d, input logic [15:0] v, input logic e, input logic iv);
      logic [15:0] best;
      logic [15:0] px;
      int bk;
      int bx;
      int by;
      @(negedge clk);
      din[d] = v;
      en[d]  = e;
      vl[d]  = iv;
      if (e && iv && rst_n) begin
         img[d][my[d]][mx[d]] = v;
         if (mx[d] % S == S - 1 && my[d] % S == S - 1 &&
             mx[d] < (W[d] / S) * S && my[d] < (H[d] / S) * S) begin
            bx = mx[d] - (S - 1);
            by = my[d] - (S - 1);
            best = '0;
            bk = 0;
            for (int k = 0; k < S * S; k++) begin
               px = img[d][by + k / S][bx + k % S];
               if (k == 0 || $signed(px) > $signed(best)) begin
                  best = px;
                  bk = k;
               end
            end
            if (d == 0) sb0.push_back({best, 16'(16'h1 << bk)});
            else        sb1.push_back({best, 16'(16'h1 << bk)});
            exp_win_at[d] = cyc + 1;
         end
         if (mx[d] == W[d] - 1 && my[d] == H[d] - 1 && mc[d] == C[d] - 1)
            exp_last_at[d] = cyc + 1;
         if (mx[d] == W[d] - 1) begin
            mx[d] = 0;
            if (my[d] == H[d] - 1) begin
               my[d] = 0;
               mc[d] = (mc[d] == C[d] - 1) ? 0 : mc[d] + 1;
            end else begin
               my[d]++;
            end
         end else begin
            mx[d]++;
         end
      end
   endtask

   task automatic idle(input int d, input int n);
      for (int i = 0; i < n; i++) drive(d, '0, 1'b0, 1'b0);
   endtask

   task automatic check_cap(input int d, input string nm, input logic [15:0] ep [8],
                            input logic [15:0] ee [8], input int n);
      logic [31:0] got;
      if (d == 0) chk({nm, "_count"}, d, 64'(cap0.size()), 64'(n));
      else        chk({nm, "_count"}, d, 64'(cap1.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (d == 0) got = (i < cap0.size()) ? cap0[i] : 32'hxxxx_xxxx;
         else        got = (i < cap1.size()) ? cap1[i] : 32'hxxxx_xxxx;
         chk({nm, "_pooled"}, d, 64'(got[31:16]), 64'(ep[i]));
         chk({nm, "_error"},  d, 64'(got[15:0]),  64'(ee[i]));
      end
   endtask

   logic        ev, ed, eb;
   logic [31:0] exp_e;

   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            chk("reset_outputs", d, 64'({ov[d], pd[d], bd[d], po[d], oe[d]}), 64'(0));
         end else begin
            ev = (exp_win_at[d] == cyc);
            ed = (exp_last_at[d] == cyc);
            eb = (exp_last_at[d] + 1 == cyc);
            chk("output_valid", d, 64'(ov[d]), 64'(ev));
            chk("pool_done", d, 64'(pd[d]), 64'(ed));
            chk("backprop_done", d, 64'(bd[d]), 64'(eb));
            if (ov[d]) begin
               if (d == 0) cap0.push_back({po[d], oe[d]});
               else        cap1.push_back({po[d], oe[d]});
            end
            if (ov[d] && ev) begin
               exp_e = 32'hxxxx_xxxx;
               if (d == 0 && sb0.size() > 0) exp_e = sb0.pop_front();
               if (d == 1 && sb1.size() > 0) exp_e = sb1.pop_front();
               chk("sb_pooled", d, 64'(po[d]), 64'(exp_e[31:16]));
               chk("sb_error",  d, 64'(oe[d]), 64'(exp_e[15:0]));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ep [8];
      logic [15:0] ee [8];

      for (int i = 0; i < 16; i++) begin
         tbl[0].px[i] = 16'(i);
         tbl[1].px[i] = 16'hFFFF;
         tbl[2].px[i] = 16'h8000;
         tbl[3].px[i] = 16'(15 - i);
      end
      tbl[0].pool = '{16'd5, 16'd7, 16'd13, 16'd15};
      tbl[0].err  = '{16'h8, 16'h8, 16'h8, 16'h8};
      tbl[1].pool = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      tbl[1].err  = '{16'h1, 16'h1, 16'h1, 16'h1};
      tbl[2].px[1]  = 16'h0100;
      tbl[2].px[4]  = 16'hFF00;
      tbl[2].px[5]  = 16'h0000;
      tbl[2].px[7]  = 16'h7FFF;
      tbl[2].px[10] = 16'h0005;
      tbl[2].px[11] = 16'h0005;
      tbl[2].px[14] = 16'h0005;
      tbl[2].px[15] = 16'h0004;
      tbl[2].pool = '{16'h0100, 16'h7FFF, 16'h8000, 16'h0005};
      tbl[2].err  = '{16'h2, 16'h8, 16'h1, 16'h1};
      tbl[3].pool = '{16'd15, 16'd13, 16'd7, 16'd5};
      tbl[3].err  = '{16'h1, 16'h1, 16'h1, 16'h1};

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         en[d]  = 1'b0;
         vl[d]  = 1'b0;
         din[d] = '0;
      end
      model_clear();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 4; t++) begin
         cap0.delete();
         for (int i = 0; i < 16; i++) drive(0, tbl[t].px[i], 1'b1, 1'b1);
         idle(0, 3);
         for (int i = 0; i < 8; i++) begin
            ep[i] = (i < 4) ? tbl[t].pool[i] : '0;
            ee[i] = (i < 4) ? tbl[t].err[i] : '0;
         end
         check_cap(0, $sformatf("table%0d", t), ep, ee, 4);
      end

      // 5x5x2: trailing column/row of each channel is dropped
      cap1.delete();
      for (int i = 0; i < 50; i++) drive(1, 16'(i), 1'b1, 1'b1);
      idle(1, 3);
      ep = '{16'd6, 16'd8, 16'd16, 16'd18, 16'd31, 16'd33, 16'd41, 16'd43};
      ee = '{16'h8, 16'h8, 16'h8, 16'h8, 16'h8, 16'h8, 16'h8, 16'h8};
      check_cap(1, "odd_dims", ep, ee, 8);

      // stalls: enable low mid-row with garbage, then input_valid gaps
      cap0.delete();
      for (int i = 0; i < 16; i++) begin
         if (i == 6) for (int j = 0; j < 3; j++) drive(0, 16'h7FFF, 1'b0, 1'b1);
         if (i == 10 || i == 13) for (int j = 0; j < 2; j++) drive(0, 16'h7FFF, 1'b1, 1'b0);
         drive(0, 16'(i), 1'b1, 1'b1);
      end
      idle(0, 3);
      ep = '{16'd5, 16'd7, 16'd13, 16'd15, 16'd0, 16'd0, 16'd0, 16'd0};
      ee = '{16'h8, 16'h8, 16'h8, 16'h8, 16'h0, 16'h0, 16'h0, 16'h0};
      check_cap(0, "stall", ep, ee, 4);

      // reset mid-frame, inputs kept active while in reset
      for (int i = 0; i < 7; i++) drive(0, 16'(100 + i), 1'b1, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      model_clear();
      din[0] = 16'h7FFF;
      en[0]  = 1'b1;
      vl[0]  = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      en[0] = 1'b0;
      cap0.delete();
      for (int i = 0; i < 16; i++) drive(0, 16'(i), 1'b1, 1'b1);
      idle(0, 3);
      check_cap(0, "after_reset", ep, ee, 4);

      idle(1, 2);
      chk("sb0_drained", 0, 64'(sb0.size()), 64'(0));
      chk("sb1_drained", 1, 64'(sb1.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
